// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use, HI/LO wait, branch flush, dmem freeze.
// Zero-latency combinational hold/clear outputs; dmem_busy freezes every stage and outranks all other requests.
module pipe_hazard_ctrl #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_reads_hilo,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_muldiv_start,
  input  logic             mem_branch_taken,
  input  logic             dmem_busy,
  output logic             hold_pc,
  output logic             hold_ifid,
  output logic             hold_idex,
  output logic             hold_exmem,
  output logic             hold_memwb,
  output logic             clear_ifid,
  output logic             clear_idex,
  output logic             clear_exmem,
  output logic             clear_memwb,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_count
);

  localparam int MDW = $clog2(MULDIV_CYCLES + 1);
  localparam logic [MDW-1:0] MD_LOAD = MDW'(MULDIV_CYCLES - 1);

  typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [MDW-1:0]   md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic lu, hl, md_accept;

  assign muldiv_busy = (state_q == MD_BUSY);
  assign stall_count = stall_count_q;

  assign lu = ex_memread && (ex_rd != 5'd0) &&
              ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
  assign hl = id_reads_hilo && muldiv_busy;

  // A start under a flush is squashed; under a freeze it comes back next cycle.
  assign md_accept = ex_muldiv_start && !mem_branch_taken && !dmem_busy;

  always_comb begin
    hold_pc     = 1'b0;
    hold_ifid   = 1'b0;
    hold_idex   = 1'b0;
    hold_exmem  = 1'b0;
    hold_memwb  = 1'b0;
    clear_ifid  = 1'b0;
    clear_idex  = 1'b0;
    clear_exmem = 1'b0;
    clear_memwb = 1'b0;
    if (!rst_n) begin
      clear_ifid  = 1'b1;
      clear_idex  = 1'b1;
      clear_exmem = 1'b1;
      clear_memwb = 1'b1;
    end else if (dmem_busy) begin
      hold_pc    = 1'b1;
      hold_ifid  = 1'b1;
      hold_idex  = 1'b1;
      hold_exmem = 1'b1;
      hold_memwb = 1'b1;
    end else if (mem_branch_taken) begin
      clear_ifid  = 1'b1;
      clear_idex  = 1'b1;
      clear_exmem = 1'b1;
    end else if (lu || hl) begin
      hold_pc    = 1'b1;
      hold_ifid  = 1'b1;
      clear_idex = 1'b1;
    end
  end

  // The mult/div unit runs on its own, so the count keeps moving through freezes and flushes.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      RUN: begin
        if (md_accept) begin
          state_d  = MD_BUSY;
          md_cnt_d = MD_LOAD;
        end
      end
      MD_BUSY: begin
        if (md_accept) begin
          md_cnt_d = MD_LOAD;
        end else if (md_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          md_cnt_d = md_cnt_q - MDW'(1);
        end
      end
      default: begin
        state_d  = RUN;
        md_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (hold_pc && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      md_cnt_q      <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      md_cnt_q      <= md_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MULDIV_CYCLES=4, CNT_W=4.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, id_reads_hilo, ex_memread;
  logic       ex_muldiv_start, mem_branch_taken, dmem_busy;
  logic       hold_pc, hold_ifid, hold_idex, hold_exmem, hold_memwb;
  logic       clear_ifid, clear_idex, clear_exmem, clear_memwb, muldiv_busy;
  logic [3:0] stall_count;

  int total  = 0;
  int passes = 0;

  // {hold_pc,hold_ifid,hold_idex,hold_exmem,hold_memwb,clear_ifid,clear_idex,clear_exmem,clear_memwb,muldiv_busy}
  logic [9:0] ctl;
  assign ctl = {hold_pc, hold_ifid, hold_idex, hold_exmem, hold_memwb,
                clear_ifid, clear_idex, clear_exmem, clear_memwb, muldiv_busy};

  localparam logic [9:0] O_IDLE  = 10'b00000_0000_0;
  localparam logic [9:0] O_RST   = 10'b00000_1111_0;
  localparam logic [9:0] O_STALL = 10'b11000_0100_0;
  localparam logic [9:0] O_FLUSH = 10'b00000_1110_0;
  localparam logic [9:0] O_FRZ   = 10'b11111_0000_0;
  localparam logic [9:0] O_BUSY  = 10'b00000_0000_1;

  pipe_hazard_ctrl #(.MULDIV_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reads_hilo(id_reads_hilo), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .ex_muldiv_start(ex_muldiv_start), .mem_branch_taken(mem_branch_taken),
    .dmem_busy(dmem_busy),
    .hold_pc(hold_pc), .hold_ifid(hold_ifid), .hold_idex(hold_idex),
    .hold_exmem(hold_exmem), .hold_memwb(hold_memwb),
    .clear_ifid(clear_ifid), .clear_idex(clear_idex), .clear_exmem(clear_exmem),
    .clear_memwb(clear_memwb), .muldiv_busy(muldiv_busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total = total + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_reads_hilo = 1'b0;
    ex_memread = 1'b0; ex_muldiv_start = 1'b0;
    mem_branch_taken = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic set_lu();
    ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("reset_ctl", 16'(ctl), 16'(O_RST));
    check("reset_cnt", 16'(stall_count), 16'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("post_reset_ctl", 16'(ctl), 16'(O_IDLE));

    // Load-use on rs
    set_lu();
    #1;
    check("lu_rs_ctl", 16'(ctl), 16'(O_STALL));
    tick();
    check("lu_rs_cnt", 16'(stall_count), 16'd1);
    ex_memread = 1'b0;
    #1;
    check("lu_bubble_ctl", 16'(ctl), 16'(O_IDLE));

    // ex_rd = 0 matches id_rs = 0 but must not stall
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
    #1;
    check("lu_rd0_ctl", 16'(ctl), 16'(O_IDLE));
    tick();
    check("lu_rd0_cnt", 16'(stall_count), 16'd1);

    // Register matches but rs is not read
    ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b0;
    #1;
    check("lu_nouse_ctl", 16'(ctl), 16'(O_IDLE));

    // rt path
    id_rt = 5'd8; id_uses_rt = 1'b1;
    #1;
    check("lu_rt_ctl", 16'(ctl), 16'(O_STALL));
    tick();
    check("lu_rt_cnt", 16'(stall_count), 16'd2);
    idle_inputs();
    #1;

    // Mult/div start then mfhi held: 4 busy/stall cycles
    ex_muldiv_start = 1'b1;
    #1;
    check("md_start_ctl", 16'(ctl), 16'(O_IDLE));
    tick();
    ex_muldiv_start = 1'b0; id_reads_hilo = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("md_wait%0d_ctl", i), 16'(ctl), 16'(O_STALL | O_BUSY));
      tick();
    end
    check("md_release_ctl", 16'(ctl), 16'(O_IDLE));
    check("md_cnt", 16'(stall_count), 16'd6);
    idle_inputs();

    // Flush with start and load-use: start dropped, no stall counted
    set_lu(); mem_branch_taken = 1'b1; ex_muldiv_start = 1'b1;
    #1;
    check("flush_ctl", 16'(ctl), 16'(O_FLUSH));
    tick();
    idle_inputs();
    #1;
    check("flush_after_ctl", 16'(ctl), 16'(O_IDLE));
    check("flush_cnt", 16'(stall_count), 16'd6);

    // Freeze for 3 cycles while a mult/div is counting down
    ex_muldiv_start = 1'b1;
    tick();
    ex_muldiv_start = 1'b0;
    set_lu(); mem_branch_taken = 1'b1; dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("frz%0d_ctl", i), 16'(ctl), 16'(O_FRZ | O_BUSY));
      tick();
    end
    idle_inputs();
    #1;
    check("frz_cnt", 16'(stall_count), 16'd9);
    check("frz_md_last_ctl", 16'(ctl), 16'(O_BUSY));
    tick();
    check("frz_md_done_ctl", 16'(ctl), 16'(O_IDLE));

    // Asynchronous reset in the middle of a mult/div wait
    ex_muldiv_start = 1'b1;
    tick();
    ex_muldiv_start = 1'b0; id_reads_hilo = 1'b1;
    #1;
    check("pre_rst_ctl", 16'(ctl), 16'(O_STALL | O_BUSY));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctl", 16'(ctl), 16'(O_RST));
    check("mid_rst_cnt", 16'(stall_count), 16'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_release_ctl", 16'(ctl), 16'(O_IDLE));
    check("rst_release_cnt", 16'(stall_count), 16'd0);
    idle_inputs();

    // Saturation at 15
    set_lu();
    for (int i = 1; i <= 20; i++) begin
      tick();
      check($sformatf("sat%0d_cnt", i), 16'(stall_count), 16'((i > 15) ? 15 : i));
    end
    check("sat_ctl", 16'(ctl), 16'(O_STALL));
    idle_inputs();
    tick();
    check("sat_hold_cnt", 16'(stall_count), 16'd15);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
